// File: rtl/div_pkg.sv
// Shared definitions for the divider-sharing controller: FSM encoding and
// default operand widths / timeout.
package div_pkg;
    localparam int XW_DEF      = 10;
    localparam int DW_DEF      = 5;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [NREQ-1:0] win_oh,
    output logic [PW-1:0]   win_idx
);
    logic [PW:0]   sum;
    logic [PW-1:0] slot;

    always_comb begin
        any     = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        sum     = '0;
        slot    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr < NREQ, so a single subtract performs the modulo wrap
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            slot = sum[PW-1:0];
            if (!any && req[slot]) begin
                any          = 1'b1;
                win_oh[slot] = 1'b1;
                win_idx      = slot;
            end
        end
    end
endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin controller sharing one divider among NREQ clients: latches the
// winner's operands, pulses div_start, then returns the result or a timeout.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int XW      = XW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*XW-1:0] req_x,
    input  logic [NREQ*DW-1:0] req_d,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_q,
    output logic [DW-1:0]      rsp_w,
    output logic               rsp_divBy0,
    output logic               rsp_ov,
    output logic               rsp_tmo,
    output logic               div_start,
    output logic [XW-1:0]      div_x,
    output logic [DW-1:0]      div_d,
    input  logic               div_done,
    input  logic [DW-1:0]      div_q,
    input  logic [DW-1:0]      div_w,
    input  logic               div_divBy0,
    input  logic               div_ov
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [XW-1:0]   x_q, x_d;
    logic [DW-1:0]   d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   q_q, q_d;
    logic [DW-1:0]   w_q, w_d;
    logic            dz_q, dz_d;
    logic            ov_q, ov_d;
    logic            tmo_q, tmo_d;

    logic            arb_any;
    logic [NREQ-1:0] arb_oh;
    logic [PW-1:0]   arb_idx;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .any     (arb_any),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        w_d     = w_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_oh;
                    idx_d   = arb_idx;
                    x_d     = req_x[arb_idx*XW +: XW];
                    d_d     = req_d[arb_idx*DW +: DW];
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    q_d     = div_q;
                    w_d     = div_w;
                    dz_d    = div_divBy0;
                    ov_d    = div_ov;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    q_d     = '0;
                    w_d     = '0;
                    dz_d    = 1'b0;
                    ov_d    = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                // the client just served drops to lowest priority next round
                ptr_d   = (idx_q == PW'(NREQ-1)) ? '0 : idx_q + PW'(1);
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            x_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            w_q     <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            w_q     <= w_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign div_start  = (state_q == START);
    assign div_x      = x_q;
    assign div_d      = d_q;
    assign rsp_valid  = (state_q == RESP) ? gnt_q : '0;
    assign rsp_q      = q_q;
    assign rsp_w      = w_q;
    assign rsp_divBy0 = dz_q;
    assign rsp_ov     = ov_q;
    assign rsp_tmo    = tmo_q;
endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural fixed-latency divider.
module tb_div_share_ctrl;
    localparam int NREQ = 4, XW = 10, DW = 5, TMO = 8, LAT = 3;

    logic               clk = 1'b0, rst = 1'b0;
    logic [NREQ-1:0]    req;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*DW-1:0] req_d;
    logic [NREQ-1:0]    gnt, rsp_valid;
    logic               busy, rsp_divBy0, rsp_ov, rsp_tmo, div_start;
    logic [DW-1:0]      rsp_q, rsp_w, div_d, div_q, div_w;
    logic [XW-1:0]      div_x;
    logic               div_done, div_divBy0, div_ov;

    div_share_ctrl #(.NREQ(NREQ), .XW(XW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_d(req_d),
        .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_w(rsp_w),
        .rsp_divBy0(rsp_divBy0), .rsp_ov(rsp_ov), .rsp_tmo(rsp_tmo),
        .div_start(div_start), .div_x(div_x), .div_d(div_d), .div_done(div_done),
        .div_q(div_q), .div_w(div_w), .div_divBy0(div_divBy0), .div_ov(div_ov)
    );

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [XW-1:0]   x;
        logic [DW-1:0]   d, q, w;
        logic            dz, ov, tmo;
        int              cyc;
    } rsp_t;
    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [XW-1:0]   x;
        logic [DW-1:0]   d;
        int              cyc;
    } st_t;

    rsp_t exp_q[$];
    rsp_t rsp_obs[$];
    st_t  st_obs[$];
    int   rd_r = 0, rd_s = 0;
    int   vectors = 0, miscompares = 0, onehot_err = 0, cyc = 0;
    bit   done_en = 1'b1;
    int   lx, ld;
    rsp_t mr;
    st_t  ms;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Divider stand-in: done LAT cycles after the start cycle, garbage otherwise
    initial begin
        div_done = 1'b0; div_q = '0; div_w = '0; div_divBy0 = 1'b0; div_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && div_start) begin
                lx = int'(div_x); ld = int'(div_d);
                repeat (LAT-1) @(negedge clk);
                if (done_en && rst) begin
                    div_done   = 1'b1;
                    div_divBy0 = (ld == 0);
                    div_q      = (ld == 0) ? '0 : DW'(lx / ld);
                    div_w      = (ld == 0) ? '0 : DW'(lx % ld);
                    div_ov     = (ld != 0) && ((lx / ld) > 31);
                    @(negedge clk);
                    div_done = 1'b0; div_q = DW'($urandom); div_w = DW'($urandom);
                    div_divBy0 = 1'b0; div_ov = 1'b0;
                end
            end
        end
    end

    // Monitor: records every start pulse and every response strobe
    initial forever begin
        @(negedge clk);
        if (div_start) begin
            ms.gnt = gnt; ms.x = div_x; ms.d = div_d; ms.cyc = cyc;
            st_obs.push_back(ms);
        end
        if (|rsp_valid) begin
            mr.vld = rsp_valid; mr.x = div_x; mr.d = div_d; mr.q = rsp_q; mr.w = rsp_w;
            mr.dz = rsp_divBy0; mr.ov = rsp_ov; mr.tmo = rsp_tmo; mr.cyc = cyc;
            rsp_obs.push_back(mr);
        end
        if (!$onehot0(gnt) || !$onehot0(rsp_valid)) onehot_err++;
    end

    function automatic rsp_t mk(logic [NREQ-1:0] v, int x, int d, int q, int w,
                                logic dz, logic ov, logic tmo);
        rsp_t r;
        r.vld = v; r.x = XW'(x); r.d = DW'(d); r.q = DW'(q); r.w = DW'(w);
        r.dz = dz; r.ov = ov; r.tmo = tmo; r.cyc = 0;
        return r;
    endfunction

    function automatic rsp_t calc(int slot, int x, int d);
        logic [NREQ-1:0] v;
        v = '0; v[slot] = 1'b1;
        return mk(v, x, d, x / d, x % d, 1'b0, (x / d) > 31, 1'b0);
    endfunction

    task automatic set_op(input int s, input int x, input int d);
        req_x[s*XW +: XW] = XW'(x);
        req_d[s*DW +: DW] = DW'(d);
    endtask

    // Wait for n more responses; served clients drop req, idle slots get scribbled
    task automatic run(input int n, input int budget, output bit to);
        int goal;
        goal = rsp_obs.size() + n;
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            for (int s = 0; s < NREQ; s++) if (rsp_valid[s]) req[s] = 1'b0;
            if (rsp_obs.size() >= goal) begin to = 1'b0; break; end
            for (int s = 0; s < NREQ; s++)
                if (!req[s] && !gnt[s]) set_op(s, $urandom_range(0, 1023), $urandom_range(0, 31));
        end
        if (to) begin
            req = '0; exp_q.delete(); rd_r = rsp_obs.size(); rd_s = st_obs.size();
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; req = '0; req_x = '0; req_d = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({gnt, busy, rsp_valid, div_start} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctl: got gnt=%b busy=%b vld=%b start=%b, want all 0", gnt, busy, rsp_valid, div_start);
        end
        vectors++;
        if ({rsp_q, rsp_w, rsp_divBy0, rsp_ov, rsp_tmo} !== '0) begin
            miscompares++;
            $display("FAIL reset_rsp: got q=%0d w=%0d f=%b%b%b, want 0", rsp_q, rsp_w, rsp_divBy0, rsp_ov, rsp_tmo);
        end
        vectors++;
        if ({div_x, div_d} !== '0) begin
            miscompares++;
            $display("FAIL reset_div: got x=%0d d=%0d, want 0", div_x, div_d);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_single;
        rsp_t e, o; st_t s; bit to; int c0;
        set_op(0, 75, 11);
        exp_q.push_back(mk(4'b0001, 75, 11, 6, 9, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        c0 = cyc; req[0] = 1'b1;
        run(1, 30, to);
        vectors++;
        if (to) begin
            miscompares++; $display("FAIL single_wait: got no rsp_valid, want one within 30 cycles");
        end else begin
            e = exp_q.pop_front(); o = rsp_obs[rd_r]; rd_r++; s = st_obs[rd_s]; rd_s++;
            vectors++;
            if ({o.vld, o.x, o.d, o.q, o.w, o.dz, o.ov, o.tmo} !== {e.vld, e.x, e.d, e.q, e.w, e.dz, e.ov, e.tmo}) begin
                miscompares++;
                $display("FAIL single_rsp: got vld=%b q=%0d w=%0d f=%b%b%b, want vld=%b q=%0d w=%0d f=%b%b%b",
                         o.vld, o.q, o.w, o.dz, o.ov, o.tmo, e.vld, e.q, e.w, e.dz, e.ov, e.tmo);
            end
            vectors++;
            if (s.cyc != c0 + 1 || o.cyc != s.cyc + LAT) begin
                miscompares++;
                $display("FAIL single_latency: got start@%0d rsp@%0d, want start@%0d rsp@%0d", s.cyc, o.cyc, c0+1, c0+1+LAT);
            end
            vectors++;
            if (st_obs.size() != rd_s) begin
                miscompares++; $display("FAIL single_start_pulse: got %0d start cycles, want 1", st_obs.size() - rd_s + 1);
            end
        end
        repeat (5) @(negedge clk);
        vectors++;
        if ({rsp_q, rsp_w} !== {5'd6, 5'd9}) begin
            miscompares++; $display("FAIL single_hold: got q=%0d w=%0d, want q=6 w=9", rsp_q, rsp_w);
        end
    endtask

    task automatic test_contention;
        rsp_t e, o; st_t s; bit to;
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 100 + 37*i, 3 + i);
            exp_q.push_back(calc(i, 100 + 37*i, 3 + i));
        end
        onehot_err = 0;
        req = '1;
        run(NREQ, 100, to);
        vectors++;
        if (to) begin
            miscompares++; $display("FAIL contention_wait: got fewer than %0d responses, want %0d", NREQ, NREQ);
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                e = exp_q.pop_front(); o = rsp_obs[rd_r]; rd_r++; s = st_obs[rd_s]; rd_s++;
                vectors++;
                if ({o.vld, o.x, o.d, o.q, o.w, o.dz, o.ov, o.tmo} !== {e.vld, e.x, e.d, e.q, e.w, e.dz, e.ov, e.tmo}) begin
                    miscompares++;
                    $display("FAIL contention_rsp[%0d]: got vld=%b x=%0d d=%0d q=%0d w=%0d ov=%b, want vld=%b x=%0d d=%0d q=%0d w=%0d ov=%b",
                             k, o.vld, o.x, o.d, o.q, o.w, o.ov, e.vld, e.x, e.d, e.q, e.w, e.ov);
                end
                vectors++;
                if ({s.gnt, s.x, s.d} !== {e.vld, e.x, e.d}) begin
                    miscompares++;
                    $display("FAIL contention_start[%0d]: got gnt=%b x=%0d d=%0d, want gnt=%b x=%0d d=%0d", k, s.gnt, s.x, s.d, e.vld, e.x, e.d);
                end
            end
        end
        vectors++;
        if (onehot_err != 0) begin
            miscompares++; $display("FAIL contention_onehot: got %0d non-one-hot cycles, want 0", onehot_err);
        end
    endtask

    task automatic test_fairness;
        rsp_t e, o; bit to, to2;
        set_op(1, 500, 7);  exp_q.push_back(calc(1, 500, 7));
        set_op(2, 321, 13); exp_q.push_back(calc(2, 321, 13));
        req = 4'b0110;
        run(1, 30, to);
        // slot 1 re-requests in the very cycle its response strobes
        set_op(1, 777, 25); exp_q.push_back(calc(1, 777, 25));
        req[1] = 1'b1;
        run(2, 60, to2);
        vectors++;
        if (to || to2) begin
            miscompares++; $display("FAIL fairness_wait: got missing responses, want 3");
        end else begin
            for (int k = 0; k < 3; k++) begin
                e = exp_q.pop_front(); o = rsp_obs[rd_r]; rd_r++; rd_s++;
                vectors++;
                if ({o.vld, o.x, o.d, o.q, o.w, o.ov} !== {e.vld, e.x, e.d, e.q, e.w, e.ov}) begin
                    miscompares++;
                    $display("FAIL fairness_order[%0d]: got vld=%b x=%0d d=%0d q=%0d w=%0d, want vld=%b x=%0d d=%0d q=%0d w=%0d",
                             k, o.vld, o.x, o.d, o.q, o.w, e.vld, e.x, e.d, e.q, e.w);
                end
            end
        end
    endtask

    task automatic test_flags;
        rsp_t e, o; bit to;
        // divisor 0 is forwarded untouched; dividend 1000/3 overflows 5 bits
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                set_op(2, 100, 0); exp_q.push_back(mk(4'b0100, 100, 0, 0, 0, 1'b1, 1'b0, 1'b0)); req = 4'b0100;
            end else begin
                set_op(3, 1000, 3); exp_q.push_back(mk(4'b1000, 1000, 3, 13, 1, 1'b0, 1'b1, 1'b0)); req = 4'b1000;
            end
            run(1, 30, to);
            vectors++;
            if (to) begin
                miscompares++; $display("FAIL flags_wait[%0d]: got no response, want one", k);
            end else begin
                e = exp_q.pop_front(); o = rsp_obs[rd_r]; rd_r++; rd_s++;
                vectors++;
                if ({o.vld, o.d, o.q, o.w, o.dz, o.ov, o.tmo} !== {e.vld, e.d, e.q, e.w, e.dz, e.ov, e.tmo}) begin
                    miscompares++;
                    $display("FAIL flags_rsp[%0d]: got vld=%b d=%0d q=%0d w=%0d dz=%b ov=%b tmo=%b, want vld=%b d=%0d q=%0d w=%0d dz=%b ov=%b tmo=%b",
                             k, o.vld, o.d, o.q, o.w, o.dz, o.ov, o.tmo, e.vld, e.d, e.q, e.w, e.dz, e.ov, e.tmo);
                end
            end
        end
    endtask

    task automatic test_timeout;
        rsp_t e, o; st_t s; bit to;
        done_en = 1'b0;
        set_op(0, 50, 7);
        exp_q.push_back(mk(4'b0001, 50, 7, 0, 0, 1'b0, 1'b0, 1'b1));
        req = 4'b0001;
        run(1, 40, to);
        vectors++;
        if (to) begin
            miscompares++; $display("FAIL timeout_wait: got no response, want tmo response");
        end else begin
            e = exp_q.pop_front(); o = rsp_obs[rd_r]; rd_r++; s = st_obs[rd_s]; rd_s++;
            vectors++;
            if ({o.vld, o.q, o.w, o.dz, o.ov, o.tmo} !== {e.vld, e.q, e.w, e.dz, e.ov, e.tmo}) begin
                miscompares++;
                $display("FAIL timeout_rsp: got vld=%b q=%0d w=%0d f=%b%b%b, want vld=%b q=0 w=0 f=001", o.vld, o.q, o.w, o.dz, o.ov, o.tmo, e.vld);
            end
            // TMO cycles spent in WAIT after the start cycle, then RESP
            vectors++;
            if (o.cyc - s.cyc != TMO + 1) begin
                miscompares++; $display("FAIL timeout_latency: got %0d cycles start->rsp, want %0d", o.cyc - s.cyc, TMO + 1);
            end
        end
        done_en = 1'b1;
    endtask

    task automatic test_reset_wait;
        st_t s; int n;
        done_en = 1'b0;
        set_op(2, 200, 9);
        req = 4'b0100;
        n = 0;
        while (st_obs.size() == rd_s && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (st_obs.size() == rd_s) begin
            miscompares++; $display("FAIL rstwait_start: got no div_start, want one");
        end else begin
            s = st_obs[rd_s]; rd_s++;
            vectors++;
            if ({s.gnt, s.x, s.d} !== {4'b0100, 10'd200, 5'd9}) begin
                miscompares++; $display("FAIL rstwait_operands: got gnt=%b x=%0d d=%0d, want gnt=0100 x=200 d=9", s.gnt, s.x, s.d);
            end
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({gnt, busy, rsp_valid, div_start, div_x, div_d, rsp_q, rsp_w, rsp_divBy0, rsp_ov, rsp_tmo} !== '0) begin
            miscompares++;
            $display("FAIL rstwait_async: got gnt=%b busy=%b x=%0d d=%0d tmo=%b, want all 0", gnt, busy, div_x, div_d, rsp_tmo);
        end
        req = '0;
        @(negedge clk); rst = 1'b1; done_en = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (rsp_obs.size() != rd_r || st_obs.size() != rd_s || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwait_quiet: got %0d rsp %0d start busy=%b, want 0 0 0", rsp_obs.size() - rd_r, st_obs.size() - rd_s, busy);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_fairness;
        test_flags;
        test_timeout;
        test_reset_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
